// File: rtl/cam_capture_ctrl_if.sv
// rtl/cam_capture_ctrl_if.sv - camera input port and frame-buffer write port bundle
// master: the capture controller; slave: camera source and frame-buffer BRAM side.
interface cam_capture_ctrl_if #(
  parameter int ADDR_W = 19
);
  logic              VSYNC;
  logic              HREF;
  logic              PCLK;
  logic [7:0]        DATA;
  logic              WE;
  logic [ADDR_W-1:0] ADDR;
  logic [15:0]       WDATA;

  modport master (
    input  VSYNC, HREF, PCLK, DATA,
    output WE, ADDR, WDATA
  );

  modport slave (
    output VSYNC, HREF, PCLK, DATA,
    input  WE, ADDR, WDATA
  );
endinterface

// File: rtl/cam_capture_ctrl.sv
// rtl/cam_capture_ctrl.sv - OV7670-style frame-capture sequencer writing RGB565 into a frame buffer
// Optional macro CAM_SUBSAMPLE_EN: write only even rows/columns into a half-resolution buffer.
module cam_capture_ctrl #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic               CONT,
  input  logic               ABORT,
  cam_capture_ctrl_if.master bus,
  output logic [9:0]         PIXEL_COLUMN,
  output logic [9:0]         PIXEL_ROW,
  output logic               BUSY,
  output logic               FRAME_DONE,
  output logic               OVERFLOW
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VS_HIGH,
    WAIT_VS_LOW,
    CAPTURE
  } state_t;

  typedef enum logic {
    BYTE1,
    BYTE2
  } phase_t;

  state_t state, state_n;
  phase_t phase;

  logic [2:0] vsync_sr, href_sr, pclk_sr;
  logic [7:0] data_s1, data_s2;

  logic vsync_rise, vsync_fall, href_fall, pclk_rise, href_act;

  logic accept_start, frame_begin, frame_end, capturing;
  logic take_byte, form_pix, line_end;

  logic [7:0]        byte1;
  logic [9:0]        col, row;
  logic [9:0]        col_eff, row_eff;
  logic              wr_sel, out_of_range;
  logic [ADDR_W-1:0] addr_calc;
  logic              cont_q, line_has_pix, pix_done, line_end_q;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic              frame_done_q, overflow_q;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  // Bit 1 of each shift register is the synchronised value, bit 2 the previous sample.
  always_ff @(posedge CLK) begin
    if (RST) begin
      vsync_sr <= '0;
      href_sr  <= '0;
      pclk_sr  <= '0;
      data_s1  <= '0;
      data_s2  <= '0;
    end else begin
      vsync_sr <= {vsync_sr[1:0], bus.VSYNC};
      href_sr  <= {href_sr[1:0], bus.HREF};
      pclk_sr  <= {pclk_sr[1:0], bus.PCLK};
      data_s1  <= bus.DATA;
      data_s2  <= data_s1;
    end
  end

  assign vsync_rise = vsync_sr[1] & ~vsync_sr[2];
  assign vsync_fall = ~vsync_sr[1] & vsync_sr[2];
  assign href_fall  = ~href_sr[1] & href_sr[2];
  assign pclk_rise  = pclk_sr[1] & ~pclk_sr[2];
  // Still counts as inside the line on the href_fall cycle so a coincident byte is kept.
  assign href_act   = href_sr[1] | href_sr[2];

`ifdef CAM_SUBSAMPLE_EN
  localparam logic [9:0] H_LIM    = 10'((H_RES + 1) / 2);
  localparam logic [9:0] V_LIM    = 10'((V_RES + 1) / 2);
  localparam int         H_STRIDE = H_RES / 2;
  assign col_eff = {1'b0, col[9:1]};
  assign row_eff = {1'b0, row[9:1]};
  assign wr_sel  = ~col[0] & ~row[0];
`else
  localparam logic [9:0] H_LIM    = 10'(H_RES);
  localparam logic [9:0] V_LIM    = 10'(V_RES);
  localparam int         H_STRIDE = H_RES;
  assign col_eff = col;
  assign row_eff = row;
  assign wr_sel  = 1'b1;
`endif

  assign out_of_range = (col_eff >= H_LIM) || (row_eff >= V_LIM);
  assign addr_calc    = ADDR_W'(row_eff) * ADDR_W'(H_STRIDE) + ADDR_W'(col_eff);

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n      = state;
    accept_start = 1'b0;
    frame_begin  = 1'b0;
    frame_end    = 1'b0;
    capturing    = 1'b0;
    if (ABORT) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            accept_start = 1'b1;
            state_n      = WAIT_VS_HIGH;
          end
        end
        WAIT_VS_HIGH: begin
          if (vsync_rise) state_n = WAIT_VS_LOW;
        end
        WAIT_VS_LOW: begin
          if (vsync_fall) begin
            frame_begin = 1'b1;
            state_n     = CAPTURE;
          end
        end
        CAPTURE: begin
          capturing = 1'b1;
          if (vsync_rise) begin
            frame_end = 1'b1;
            state_n   = cont_q ? WAIT_VS_LOW : IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign take_byte = capturing & pclk_rise & href_act;
  assign form_pix  = take_byte & (phase == BYTE2);
  assign line_end  = capturing & href_fall;

  // Counter updates lag the pixel by one cycle so WE sees the pixel's own row/column.
  always_ff @(posedge CLK) begin
    if (RST) begin
      phase        <= BYTE1;
      byte1        <= '0;
      col          <= '0;
      row          <= '0;
      cont_q       <= 1'b0;
      line_has_pix <= 1'b0;
      pix_done     <= 1'b0;
      line_end_q   <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      we_q         <= 1'b0;
      frame_done_q <= frame_end;
      if (accept_start) begin
        cont_q     <= CONT;
        overflow_q <= 1'b0;
      end
      if (frame_begin) begin
        col          <= '0;
        row          <= '0;
        phase        <= BYTE1;
        line_has_pix <= 1'b0;
        pix_done     <= 1'b0;
        line_end_q   <= 1'b0;
      end else begin
        pix_done   <= form_pix;
        line_end_q <= line_end & (line_has_pix | form_pix);
        if (take_byte) begin
          if (phase == BYTE1) begin
            byte1 <= data_s2;
            phase <= BYTE2;
          end else begin
            phase        <= BYTE1;
            line_has_pix <= 1'b1;
            wdata_q      <= {byte1, data_s2};
            addr_q       <= addr_calc;
            if (out_of_range) overflow_q <= 1'b1;
            else              we_q       <= wr_sel;
          end
        end
        if (line_end) begin
          phase        <= BYTE1;
          line_has_pix <= 1'b0;
        end
        if (line_end_q) begin
          col <= '0;
          row <= sat_inc(row);
        end else if (pix_done) begin
          col <= sat_inc(col);
        end
      end
    end
  end

  assign bus.WE       = we_q;
  assign bus.ADDR     = addr_q;
  assign bus.WDATA    = wdata_q;
  assign PIXEL_COLUMN = col;
  assign PIXEL_ROW    = row;
  assign BUSY         = (state != IDLE);
  assign FRAME_DONE   = frame_done_q;
  assign OVERFLOW     = overflow_q;

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// tb/tb_cam_capture_ctrl.sv - directed self-checking bench for cam_capture_ctrl
// Camera PCLK runs at CLK/8; a 4x3 frame buffer geometry keeps frames short.
module tb_cam_capture_ctrl;
  localparam int H_RES  = 4;
  localparam int V_RES  = 3;
  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic cont = 1'b0;
  logic abort = 1'b0;
  logic [9:0] pixel_column, pixel_row;
  logic busy, frame_done, overflow;

  int tests = 0;
  int fails = 0;
  int we_total = 0;
  int fd_total = 0;

  logic [ADDR_W-1:0] log_addr  [0:255];
  logic [15:0]       log_wdata [0:255];
  logic [9:0]        log_row   [0:255];
  logic [9:0]        log_col   [0:255];

  cam_capture_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  cam_capture_ctrl #(.H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W)) dut (
    .CLK(clk), .RST(rst), .START(start), .CONT(cont), .ABORT(abort),
    .bus(bus),
    .PIXEL_COLUMN(pixel_column), .PIXEL_ROW(pixel_row),
    .BUSY(busy), .FRAME_DONE(frame_done), .OVERFLOW(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.WE === 1'b1) begin
      if (we_total < 256) begin
        log_addr[we_total]  = bus.ADDR;
        log_wdata[we_total] = bus.WDATA;
        log_row[we_total]   = pixel_row;
        log_col[we_total]   = pixel_column;
      end
      we_total++;
    end
    if (frame_done === 1'b1) fd_total++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic cam_byte(input logic [7:0] b);
    bus.DATA = b;
    bus.PCLK = 1'b0;
    tick(4);
    bus.PCLK = 1'b1;
    tick(4);
  endtask

  task automatic cam_line(input int n, input logic [7:0] first);
    logic [7:0] b;
    bus.HREF = 1'b1;
    for (int i = 0; i < n; i++) begin
      b = first + 8'(i);
      cam_byte(b);
    end
    bus.PCLK = 1'b0;
    tick(2);
    bus.HREF = 1'b0;
    tick(8);
  endtask

  task automatic cam_frame(input int nl, input int nb, input logic [7:0] first);
    logic [7:0] b;
    bus.VSYNC = 1'b0;
    tick(10);
    for (int l = 0; l < nl; l++) begin
      b = first + 8'(l * nb);
      cam_line(nb, b);
    end
    bus.VSYNC = 1'b1;
    tick(10);
  endtask

  task automatic test_reset;
    int wb;
    tests++;
    if (bus.WE !== 1'b0 || bus.ADDR !== '0 || bus.WDATA !== '0) begin
      fails++;
      $display("FAIL reset_bus: WE=%b ADDR=%0h WDATA=%0h, want all 0", bus.WE, bus.ADDR, bus.WDATA);
    end
    tests++;
    if (pixel_column !== 10'd0 || pixel_row !== 10'd0 || busy !== 1'b0 ||
        frame_done !== 1'b0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL reset_status: col=%0d row=%0d busy=%b fd=%b ovf=%b, want all 0",
               pixel_column, pixel_row, busy, frame_done, overflow);
    end
    cont = 1'b0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    cam_frame(0, 0, 8'h00);
    bus.VSYNC = 1'b0;
    tick(10);
    bus.HREF = 1'b1;
    cam_byte(8'hA0);
    cam_byte(8'hA1);
    cam_byte(8'hA2);
    rst = 1'b1;
    tick(3);
    tests++;
    if (bus.WE !== 1'b0 || busy !== 1'b0 || pixel_column !== 10'd0 || pixel_row !== 10'd0 ||
        bus.ADDR !== '0 || bus.WDATA !== '0 || frame_done !== 1'b0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_capture: WE=%b busy=%b col=%0d row=%0d ADDR=%0h WDATA=%0h, want all 0",
               bus.WE, busy, pixel_column, pixel_row, bus.ADDR, bus.WDATA);
    end
    rst = 1'b0;
    wb = we_total;
    cam_byte(8'hA3);
    cam_byte(8'hA4);
    bus.PCLK = 1'b0;
    tick(2);
    bus.HREF = 1'b0;
    tick(8);
    bus.VSYNC = 1'b1;
    tick(10);
    tests++;
    if (we_total !== wb || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_no_we_after: writes=%0d busy=%b, want 0 writes busy=0", we_total - wb, busy);
    end
  endtask

  task automatic test_single_frame;
    int wb, fb, idx;
    logic [15:0] exp;
    wb = we_total;
    fb = fd_total;
    cont = 1'b0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL single_busy_after_start: busy=%b, want 1", busy);
    end
    cam_frame(0, 0, 8'h00);
    cam_frame(3, 8, 8'h00);
    tests++;
    if (we_total - wb !== 12) begin
      fails++;
      $display("FAIL single_write_count: got %0d, want 12", we_total - wb);
    end
    for (int k = 0; k < 12; k++) begin
      idx = wb + k;
      exp = {8'(2 * k), 8'(2 * k + 1)};
      if (idx < we_total) begin
        tests++;
        if (log_addr[idx] !== ADDR_W'(k) || log_wdata[idx] !== exp ||
            log_row[idx] !== 10'(k / 4) || log_col[idx] !== 10'(k % 4)) begin
          fails++;
          $display("FAIL single_pixel_%0d: addr=%0d wdata=%h row=%0d col=%0d, want addr=%0d wdata=%h row=%0d col=%0d",
                   k, log_addr[idx], log_wdata[idx], log_row[idx], log_col[idx], k, exp, k / 4, k % 4);
        end
      end
    end
    tests++;
    if (fd_total - fb !== 1 || busy !== 1'b0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL single_done: frame_done=%0d busy=%b ovf=%b, want 1 0 0", fd_total - fb, busy, overflow);
    end
  endtask

  task automatic test_mid_frame_arm;
    int wb, fb;
    wb = we_total;
    fb = fd_total;
    bus.VSYNC = 1'b0;
    tick(10);
    cam_line(8, 8'h80);
    cont = 1'b0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    cam_line(8, 8'h88);
    cam_line(8, 8'h90);
    bus.VSYNC = 1'b1;
    tick(10);
    tests++;
    if (we_total !== wb || busy !== 1'b1) begin
      fails++;
      $display("FAIL arm_partial_frame: writes=%0d busy=%b, want 0 writes busy=1", we_total - wb, busy);
    end
    cam_frame(3, 8, 8'h40);
    tests++;
    if (we_total - wb !== 12 || fd_total - fb !== 1) begin
      fails++;
      $display("FAIL arm_frame_counts: writes=%0d frame_done=%0d, want 12 1", we_total - wb, fd_total - fb);
    end
    tests++;
    if (log_addr[wb] !== '0 || log_wdata[wb] !== 16'h4041) begin
      fail_first_arm(log_addr[wb], log_wdata[wb]);
    end
  endtask

  task automatic fail_first_arm(input logic [ADDR_W-1:0] a, input logic [15:0] d);
    fails++;
    $display("FAIL arm_first_write: addr=%0d wdata=%h, want addr=0 wdata=4041", a, d);
  endtask

  task automatic test_odd_line_overflow;
    int wb, fb;
    wb = we_total;
    fb = fd_total;
    cont = 1'b0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    cam_frame(0, 0, 8'h00);
    bus.VSYNC = 1'b0;
    tick(10);
    cam_line(9, 8'h00);
    tests++;
    if (we_total - wb !== 4 || log_wdata[wb + 3] !== 16'h0607) begin
      fails++;
      $display("FAIL odd_line_writes: writes=%0d last=%h, want 4 last=0607", we_total - wb, log_wdata[wb + 3]);
    end
    cam_line(8, 8'h09);
    tests++;
    if (log_addr[wb + 4] !== ADDR_W'(4) || log_wdata[wb + 4] !== 16'h090A ||
        log_col[wb + 4] !== 10'd0 || log_row[wb + 4] !== 10'd1) begin
      fails++;
      $display("FAIL odd_next_line: addr=%0d wdata=%h col=%0d row=%0d, want 4 090a 0 1",
               log_addr[wb + 4], log_wdata[wb + 4], log_col[wb + 4], log_row[wb + 4]);
    end
    cam_line(8, 8'h11);
    tests++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL ovf_early: ovf=%b, want 0 before fourth line", overflow);
    end
    cam_line(8, 8'h19);
    bus.VSYNC = 1'b1;
    tick(10);
    tests++;
    if (we_total - wb !== 12 || log_addr[wb + 11] !== ADDR_W'(11) || log_wdata[wb + 11] !== 16'h1718) begin
      fails++;
      $display("FAIL ovf_writes: writes=%0d last addr=%0d wdata=%h, want 12 11 1718",
               we_total - wb, log_addr[wb + 11], log_wdata[wb + 11]);
    end
    tests++;
    if (overflow !== 1'b1 || fd_total - fb !== 1) begin
      fails++;
      $display("FAIL ovf_flag: ovf=%b frame_done=%0d, want 1 1", overflow, fd_total - fb);
    end
    tick(20);
    tests++;
    if (overflow !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL ovf_sticky: ovf=%b busy=%b, want 1 0", overflow, busy);
    end
  endtask

  task automatic test_continuous;
    int wb, fb, wa;
    wb = we_total;
    fb = fd_total;
    cont = 1'b1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    cont = 1'b0;
    tests++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL cont_ovf_cleared: ovf=%b, want 0", overflow);
    end
    cam_frame(0, 0, 8'h00);
    cam_frame(3, 8, 8'h00);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    cam_frame(3, 8, 8'h20);
    tests++;
    if (busy !== 1'b1 || fd_total - fb !== 2 || we_total - wb !== 24) begin
      fails++;
      $display("FAIL cont_two_frames: busy=%b frame_done=%0d writes=%0d, want 1 2 24",
               busy, fd_total - fb, we_total - wb);
    end
    tests++;
    if (log_addr[wb + 12] !== '0 || log_wdata[wb + 12] !== 16'h2021) begin
      fails++;
      $display("FAIL cont_frame2_first: addr=%0d wdata=%h, want 0 2021", log_addr[wb + 12], log_wdata[wb + 12]);
    end
    bus.VSYNC = 1'b0;
    tick(10);
    bus.HREF = 1'b1;
    cam_byte(8'h50);
    cam_byte(8'h51);
    cam_byte(8'h52);
    cam_byte(8'h53);
    bus.DATA = 8'h54;
    bus.PCLK = 1'b0;
    tick(2);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle: busy=%b, want 0", busy);
    end
    wa = we_total;
    cam_byte(8'h54);
    cam_byte(8'h55);
    bus.PCLK = 1'b0;
    tick(2);
    bus.HREF = 1'b0;
    tick(8);
    bus.VSYNC = 1'b1;
    tick(10);
    tests++;
    if (we_total !== wa || wa - wb !== 26 || fd_total - fb !== 2) begin
      fails++;
      $display("FAIL abort_counts: writes after abort=%0d total=%0d frame_done=%0d, want 0 26 2",
               we_total - wa, wa - wb, fd_total - fb);
    end
    tests++;
    if (log_addr[wb + 24] !== '0 || log_wdata[wb + 24] !== 16'h5051 ||
        log_addr[wb + 25] !== ADDR_W'(1) || log_wdata[wb + 25] !== 16'h5253) begin
      fails++;
      $display("FAIL abort_partial: %0d/%h %0d/%h, want 0/5051 1/5253",
               log_addr[wb + 24], log_wdata[wb + 24], log_addr[wb + 25], log_wdata[wb + 25]);
    end
  endtask

  task automatic test_subsample;
    int wb, fb, idx;
    logic [15:0] exp_d [0:3];
    logic [9:0]  exp_r [0:3];
    logic [9:0]  exp_c [0:3];
    exp_d[0] = 16'h0001; exp_r[0] = 10'd0; exp_c[0] = 10'd0;
    exp_d[1] = 16'h0405; exp_r[1] = 10'd0; exp_c[1] = 10'd2;
    exp_d[2] = 16'h1011; exp_r[2] = 10'd2; exp_c[2] = 10'd0;
    exp_d[3] = 16'h1415; exp_r[3] = 10'd2; exp_c[3] = 10'd2;
    wb = we_total;
    fb = fd_total;
    cont = 1'b0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    cam_frame(0, 0, 8'h00);
    cam_frame(3, 8, 8'h00);
    tests++;
    if (we_total - wb !== 4 || fd_total - fb !== 1 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL sub_counts: writes=%0d frame_done=%0d ovf=%b, want 4 1 0",
               we_total - wb, fd_total - fb, overflow);
    end
    for (int k = 0; k < 4; k++) begin
      idx = wb + k;
      if (idx < we_total) begin
        tests++;
        if (log_addr[idx] !== ADDR_W'(k) || log_wdata[idx] !== exp_d[k] ||
            log_row[idx] !== exp_r[k] || log_col[idx] !== exp_c[k]) begin
          fails++;
          $display("FAIL sub_pixel_%0d: addr=%0d wdata=%h row=%0d col=%0d, want %0d %h %0d %0d",
                   k, log_addr[idx], log_wdata[idx], log_row[idx], log_col[idx],
                   k, exp_d[k], exp_r[k], exp_c[k]);
        end
      end
    end
  endtask

  initial begin
    bus.VSYNC = 1'b1;
    bus.HREF  = 1'b0;
    bus.PCLK  = 1'b0;
    bus.DATA  = 8'h00;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    test_reset();
`ifdef CAM_SUBSAMPLE_EN
    test_subsample();
`else
    test_single_frame();
    test_mid_frame_arm();
    test_odd_line_overflow();
    test_continuous();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
